// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the Simple RISC Machine access unit: command, address,
// write data out; read data and ready handshake back.
interface mem_access_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              mem_ready;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data,
    input  mem_ready
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data,
    output mem_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// PC and memory-access sequencer: runs fetch/load/store requests against a
// variable-latency memory with a wait-state timeout, and applies PC updates.
module mem_access_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              pc_we,
  input  logic [1:0]        pc_sel,
  input  logic [7:0]        offset,
  input  logic [ADDR_W-1:0] target,
  mem_access_unit_if.master mem,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    STORE = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [CNT_W-1:0]  wait_cnt;
  logic [1:0]        mem_cmd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] write_data_q;
  logic              mem_ready;
  logic [DATA_W-1:0] read_data;
  logic              in_access;
  logic              timeout_hit;

  assign mem_ready      = mem.mem_ready;
  assign read_data      = mem.read_data;
  assign mem.mem_cmd    = mem_cmd_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.write_data = write_data_q;

  assign in_access   = (state == FETCH) || (state == LOAD) || (state == STORE);
  // A ready in the same cycle the counter hits the limit still completes the access.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));

  always_comb begin
    state_n = state;
    pc_n    = pc;
    case (state)
      IDLE: begin
        if (pc_we) begin
          case (pc_sel)
            2'b01:   pc_n = pc + ADDR_W'($signed(offset));
            2'b10:   pc_n = target;
            2'b11:   pc_n = ADDR_W'(RESET_PC);
            default: pc_n = pc;
          endcase
        end
        if (fetch_req) begin
          state_n = FETCH;
        end else if (ld_req) begin
          state_n = LOAD;
        end else if (st_req) begin
          state_n = STORE;
        end
      end
      FETCH, LOAD, STORE: begin
        if (mem_ready) begin
          state_n = IDLE;
          if (state == FETCH) begin
            pc_n = pc + ADDR_W'(1);
          end
        end else if (timeout_hit) begin
          state_n = ERR;
        end
      end
      default: state_n = ERR;
    endcase
  end

  // Bus outputs are registered from the next state so they never follow request inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= ADDR_W'(RESET_PC);
      ir           <= '0;
      load_data    <= '0;
      write_data_q <= '0;
      mem_cmd_q    <= CMD_NONE;
      mem_addr_q   <= ADDR_W'(RESET_PC);
      wait_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      busy  <= (state_n != IDLE);
      done  <= 1'b0;
      if (state_n == ERR) begin
        err <= 1'b1;
      end

      case (state_n)
        FETCH, LOAD: mem_cmd_q <= CMD_READ;
        STORE:       mem_cmd_q <= CMD_WRITE;
        default:     mem_cmd_q <= CMD_NONE;
      endcase

      if ((state_n == LOAD) || (state_n == STORE)) begin
        if (state == IDLE) begin
          mem_addr_q <= data_addr;
        end
      end else begin
        mem_addr_q <= pc_n;
      end

      if (state == IDLE) begin
        wait_cnt <= '0;
        if (!fetch_req && !ld_req && st_req) begin
          write_data_q <= store_data;
        end
      end else if (in_access) begin
        if (mem_ready) begin
          done <= 1'b1;
          if (state == FETCH) begin
            ir <= read_data;
          end
          if (state == LOAD) begin
            load_data <= read_data;
          end
        end else if ((TIMEOUT != 0) && !timeout_hit) begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch/load/store sequencing, PC updates,
// timeout behaviour and asynchronous abort, with hand-computed expectations.
module tb_mem_access_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_req = 1'b0;
  logic              ld_req = 1'b0;
  logic              st_req = 1'b0;
  logic [ADDR_W-1:0] data_addr = '0;
  logic [DATA_W-1:0] store_data = '0;
  logic              pc_we = 1'b0;
  logic [1:0]        pc_sel = 2'b00;
  logic [7:0]        offset = 8'h00;
  logic [ADDR_W-1:0] target = '0;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] load_data;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

  mem_access_unit #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RESET_PC(0),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_req(fetch_req),
    .ld_req(ld_req),
    .st_req(st_req),
    .data_addr(data_addr),
    .store_data(store_data),
    .pc_we(pc_we),
    .pc_sel(pc_sel),
    .offset(offset),
    .target(target),
    .mem(mem_bus),
    .pc(pc),
    .ir(ir),
    .load_data(load_data),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic apply_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem_bus.read_data = '0;
    mem_bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check_output("rst_pc", 32'(pc), 32'h0);
    check_output("rst_ir", 32'(ir), 32'h0);
    check_output("rst_load_data", 32'(load_data), 32'h0);
    check_output("rst_write_data", 32'(mem_bus.write_data), 32'h0);
    check_output("rst_mem_cmd", 32'(mem_bus.mem_cmd), 32'h0);
    check_output("rst_mem_addr", 32'(mem_bus.mem_addr), 32'h0);
    check_output("rst_flags", {29'd0, busy, done, err}, 32'h0);

    // Zero-wait fetch from the reset PC.
    fetch_req = 1'b1;
    mem_bus.mem_ready = 1'b1;
    mem_bus.read_data = 16'hD105;
    apply_cycle();
    fetch_req = 1'b0;
    check_output("fetch_cmd", 32'(mem_bus.mem_cmd), 32'h1);
    check_output("fetch_addr", 32'(mem_bus.mem_addr), 32'h000);
    check_output("fetch_busy_done", {30'd0, busy, done}, 32'h2);
    apply_cycle();
    check_output("fetch_ir", 32'(ir), 32'hD105);
    check_output("fetch_pc", 32'(pc), 32'h001);
    check_output("fetch_done", {30'd0, busy, done}, 32'h1);
    check_output("fetch_idle_cmd", 32'(mem_bus.mem_cmd), 32'h0);
    check_output("fetch_idle_addr", 32'(mem_bus.mem_addr), 32'h001);
    apply_cycle();
    check_output("fetch_done_drop", 32'(done), 32'h0);
    mem_bus.mem_ready = 1'b0;

    // Load with three wait states.
    ld_req = 1'b1;
    data_addr = 9'h0A5;
    mem_bus.read_data = 16'h1234;
    apply_cycle();
    ld_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check_output($sformatf("load_cmd_c%0d", i), 32'(mem_bus.mem_cmd), 32'h1);
      check_output($sformatf("load_addr_c%0d", i), 32'(mem_bus.mem_addr), 32'h0A5);
      if (i == 4) mem_bus.mem_ready = 1'b1;
      apply_cycle();
    end
    mem_bus.mem_ready = 1'b0;
    check_output("load_data", 32'(load_data), 32'h1234);
    check_output("load_pc", 32'(pc), 32'h001);
    check_output("load_ir_kept", 32'(ir), 32'hD105);
    check_output("load_done", 32'(done), 32'h1);

    // Store whose address/data inputs change after acceptance.
    st_req = 1'b1;
    data_addr = 9'h010;
    store_data = 16'hBEEF;
    apply_cycle();
    st_req = 1'b0;
    data_addr = 9'h1FF;
    store_data = 16'h0000;
    for (int i = 1; i <= 2; i++) begin
      check_output($sformatf("store_cmd_c%0d", i), 32'(mem_bus.mem_cmd), 32'h2);
      check_output($sformatf("store_addr_c%0d", i), 32'(mem_bus.mem_addr), 32'h010);
      check_output($sformatf("store_wdata_c%0d", i), 32'(mem_bus.write_data), 32'hBEEF);
      if (i == 2) mem_bus.mem_ready = 1'b1;
      apply_cycle();
    end
    mem_bus.mem_ready = 1'b0;
    check_output("store_done", 32'(done), 32'h1);
    check_output("store_wdata_held", 32'(mem_bus.write_data), 32'hBEEF);
    check_output("store_idle_addr", 32'(mem_bus.mem_addr), 32'h001);
    check_output("store_idle_cmd", 32'(mem_bus.mem_cmd), 32'h0);

    // PC updates: absolute, relative wrap both ways, hold, reset value.
    pc_we = 1'b1;
    pc_sel = 2'b10;
    target = 9'h1FE;
    apply_cycle();
    check_output("pc_abs_1fe", 32'(pc), 32'h1FE);
    check_output("pc_abs_addr", 32'(mem_bus.mem_addr), 32'h1FE);
    pc_sel = 2'b01;
    offset = 8'h04;
    apply_cycle();
    check_output("pc_rel_wrap_up", 32'(pc), 32'h002);
    offset = 8'hFC;
    apply_cycle();
    check_output("pc_rel_wrap_down", 32'(pc), 32'h1FE);
    pc_sel = 2'b10;
    target = 9'h0C0;
    apply_cycle();
    check_output("pc_abs_0c0", 32'(pc), 32'h0C0);
    pc_sel = 2'b00;
    apply_cycle();
    check_output("pc_hold", 32'(pc), 32'h0C0);
    pc_sel = 2'b11;
    apply_cycle();
    check_output("pc_reset_sel", 32'(pc), 32'h000);
    pc_we = 1'b0;

    // Fetch + load + PC write together: fetch wins at the new PC, load dropped.
    fetch_req = 1'b1;
    ld_req = 1'b1;
    data_addr = 9'h0A5;
    pc_we = 1'b1;
    pc_sel = 2'b10;
    target = 9'h040;
    apply_cycle();
    fetch_req = 1'b0;
    ld_req = 1'b0;
    pc_sel = 2'b11;
    check_output("combo_cmd", 32'(mem_bus.mem_cmd), 32'h1);
    check_output("combo_addr", 32'(mem_bus.mem_addr), 32'h040);
    check_output("combo_pc", 32'(pc), 32'h040);
    apply_cycle();
    pc_we = 1'b0;
    check_output("pc_we_ignored_busy", 32'(pc), 32'h040);
    check_output("combo_still_fetch", 32'(mem_bus.mem_cmd), 32'h1);

    // Asynchronous abort: no clock edge between assertion and sampling.
    #1 reset = 1'b1;
    #1;
    check_output("async_cmd", 32'(mem_bus.mem_cmd), 32'h0);
    check_output("async_pc", 32'(pc), 32'h000);
    check_output("async_ir", 32'(ir), 32'h0);
    check_output("async_busy", 32'(busy), 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("post_abort_idle", {29'd0, mem_bus.mem_cmd, busy}, 32'h0);

    // Ready arriving exactly on the timeout cycle completes normally.
    mem_bus.read_data = 16'hABCD;
    fetch_req = 1'b1;
    apply_cycle();
    fetch_req = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin
        check_output("edge_cmd_c16", 32'(mem_bus.mem_cmd), 32'h1);
        check_output("edge_err_c16", 32'(err), 32'h0);
        mem_bus.mem_ready = 1'b1;
      end
      apply_cycle();
    end
    mem_bus.mem_ready = 1'b0;
    check_output("edge_done", 32'(done), 32'h1);
    check_output("edge_err", 32'(err), 32'h0);
    check_output("edge_ir", 32'(ir), 32'hABCD);
    check_output("edge_pc", 32'(pc), 32'h001);

    // Timeout: 16 unanswered access cycles enter ERR.
    fetch_req = 1'b1;
    apply_cycle();
    fetch_req = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) check_output("to_cmd_c16", 32'(mem_bus.mem_cmd), 32'h1);
      apply_cycle();
    end
    check_output("to_err", 32'(err), 32'h1);
    check_output("to_cmd", 32'(mem_bus.mem_cmd), 32'h0);
    check_output("to_busy", 32'(busy), 32'h1);
    check_output("to_addr", 32'(mem_bus.mem_addr), 32'h001);
    fetch_req = 1'b1;
    mem_bus.mem_ready = 1'b1;
    repeat (2) apply_cycle();
    check_output("err_sticky", {29'd0, busy, done, err}, 32'h5);
    check_output("err_no_fetch", 32'(mem_bus.mem_cmd), 32'h0);
    check_output("err_ir_kept", 32'(ir), 32'hABCD);
    fetch_req = 1'b0;
    mem_bus.mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("err_cleared", {29'd0, busy, done, err}, 32'h0);
    check_output("err_reset_pc", 32'(pc), 32'h000);

    // Back-to-back zero-wait fetches every two cycles.
    mem_bus.mem_ready = 1'b1;
    mem_bus.read_data = 16'h1111;
    fetch_req = 1'b1;
    apply_cycle();
    check_output("b2b_cmd1", 32'(mem_bus.mem_cmd), 32'h1);
    check_output("b2b_addr1", 32'(mem_bus.mem_addr), 32'h000);
    apply_cycle();
    check_output("b2b_done1", {30'd0, busy, done}, 32'h1);
    check_output("b2b_pc1", 32'(pc), 32'h001);
    mem_bus.read_data = 16'h2222;
    apply_cycle();
    check_output("b2b_cmd2", 32'(mem_bus.mem_cmd), 32'h1);
    check_output("b2b_addr2", 32'(mem_bus.mem_addr), 32'h001);
    fetch_req = 1'b0;
    apply_cycle();
    check_output("b2b_ir2", 32'(ir), 32'h2222);
    check_output("b2b_pc2", 32'(pc), 32'h002);
    mem_bus.mem_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised program-counter and memory-access unit for the Simple RISC Machine. It supersedes the fixed 9-bit PC, instruction-register and data-address logic in the CPU top level. The controller FSM issues fetch, load and store requests; the unit sequences them against a variable-latency memory using a `mem_ready` handshake, with a wait-state timeout. It also provides sequential, relative and absolute PC updates.

## Interface
Parameters:
- `DATA_W`, 16: instruction/data word width.
- `ADDR_W`, 9: memory address and PC width.
- `RESET_PC`, 0: PC value loaded on reset.
- `TIMEOUT`, 15: maximum wait cycles per access before error; 0 disables the timeout.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `fetch_req` input 1: request an instruction fetch from `pc`.
- `ld_req` input 1: request a data read from `data_addr`.
- `st_req` input 1: request a data write of `store_data` to `data_addr`.
- `data_addr` input ADDR_W: load/store address; captured when the request is accepted.
- `store_data` input DATA_W: store data; captured when the request is accepted.
- `pc_we` input 1: commit a PC update selected by `pc_sel`.
- `pc_sel` input 2: PC source select. 00 = hold; 01 = pc + sign-extended `offset`; 10 = `target`; 11 = `RESET_PC`.
- `offset` input 8: signed relative branch offset.
- `target` input ADDR_W: absolute branch target (register-indirect).
- `read_data` input DATA_W: memory read data.
- `mem_ready` input 1: memory completes the current access in this cycle.
- `mem_cmd` output 2: memory command. 00 = NONE, 01 = READ, 10 = WRITE.
- `mem_addr` output ADDR_W: memory address.
- `write_data` output DATA_W: memory write data.
- `pc` output ADDR_W: current PC.
- `ir` output DATA_W: instruction register.
- `load_data` output DATA_W: last loaded data word.
- `busy` output 1: a request is in progress (state other than IDLE).
- `done` output 1: one-cycle pulse when an access completes.
- `err` output 1: sticky timeout error flag.

## Operation
States:
- IDLE: `mem_cmd`=NONE. Accepts at most one request per edge, priority fetch > load > store; lower-priority requests presented in the same cycle are dropped, and the controller re-asserts them. Transitions: `fetch_req` -> FETCH; `ld_req` -> LOAD; `st_req` -> STORE.
- FETCH: `mem_cmd`=READ, `mem_addr`=`pc`. On `mem_ready`: `ir` <= `read_data`, `pc` <= `pc`+1 (mod 2^ADDR_W), `done` <= 1, -> IDLE.
- LOAD: `mem_cmd`=READ, `mem_addr`=captured address. On `mem_ready`: `load_data` <= `read_data`, `done` <= 1, -> IDLE.
- STORE: `mem_cmd`=WRITE, `mem_addr`=captured address, `write_data`=captured data. On `mem_ready`: `done` <= 1, -> IDLE.
- ERR: `mem_cmd`=NONE, `err`=1, `busy`=1. Exit only via `reset`.

Address and data outputs:
- In IDLE and ERR, `mem_addr`=`pc` and `write_data` holds its last captured value.
- `mem_cmd`, `mem_addr` and `write_data` are decoded from the state and the captured registers only, never combinationally from request inputs.

Wait-state counter:
- Cleared on every request acceptance; increments each access-state cycle without `mem_ready`.
- If it reaches TIMEOUT, the next edge enters ERR. `mem_ready` in that same cycle wins: the access completes normally.
- TIMEOUT=0: waits indefinitely.

PC update (`pc_we`):
- Honoured only in IDLE; ignored in all other states.
- Relative: `pc` + sign-extended `offset`, truncated to ADDR_W, wrapping. Because `pc` is already post-incremented after a fetch, this equals PC+1+offset.
- `pc_we` together with `fetch_req` in the same IDLE cycle: the PC updates at that edge, and the fetch uses the new `pc`.

## Timing
- Reset values: state IDLE, `pc`=RESET_PC, `ir`=0, `load_data`=0, `write_data`=0, `mem_cmd`=NONE, `mem_addr`=RESET_PC, `done`=0, `err`=0, `busy`=0, wait counter=0.
- Reset asserted mid-access aborts it immediately, with no clock needed: `mem_cmd` drops to NONE asynchronously, and `ir`/`load_data`/`pc` take their reset values.
- Request latency:
  - Request sampled at edge E0; access state and `mem_cmd` are valid in cycle E0..E1.
  - With `mem_ready` high in the first access cycle, the result and `done` are valid after E1. Minimum of 2 edges from request to `done`.
  - Each cycle without `mem_ready` adds one cycle.
- `done` is high for exactly one cycle and coincides with IDLE, so a new request in that cycle is accepted, giving back-to-back accesses every 2 cycles at zero wait.
- `mem_ready` in IDLE or ERR is ignored.

## Test plan
- Reset then fetch, `mem_ready` tied 1, `read_data`=16'hD105, RESET_PC=0: READ at addr 0 for 1 cycle; then `ir`=D105, `pc`=1, `done` pulses once, 2 cycles total.
- Load from `data_addr`=9'h0A5 with 3 wait cycles, `read_data`=16'h1234: `mem_cmd`=01 and `mem_addr`=0A5 held 4 cycles; `load_data`=1234; `pc` unchanged.
- Store 16'hBEEF to 9'h010, with `data_addr`/`store_data` changed the cycle after acceptance: WRITE to 010 with `write_data`=BEEF throughout.
- From `pc`=9'h1FE, relative branch `offset`=8'h04 -> `pc`=9'h002 (wrap); `offset`=8'hFC from 9'h002 -> 9'h1FE; `pc_sel`=10 with `target`=9'h0C0 -> 0C0.
- TIMEOUT=15, `mem_ready` held 0 during a fetch: after 16 access cycles state is ERR, `err`=1, `mem_cmd`=NONE. Fetch requests are ignored until reset, which clears `err` and sets `pc`=RESET_PC.
- Simultaneous `fetch_req`, `ld_req`, `pc_we` (target 9'h040) in IDLE: the fetch is issued at addr 040, the load is dropped. A reset pulse mid-fetch forces `mem_cmd`=NONE before the next clock edge.
